// File: rtl/conv_pipe_unit.sv
// conv_pipe_unit: three-stage pipelined 3x3 convolution with fixed, pass-through
// and software-loaded kernels, one result per beat behind a valid/ready handshake.
module conv_pipe_unit #(
    parameter int PIX_W   = 4,
    parameter int COEF_W  = 5,
    parameter int SHIFT_W = 3,
    parameter int SAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*PIX_W-1:0]   win_in,
    input  logic [2:0]           func,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     data_out,
    input  logic                 coef_we,
    input  logic [3:0]           coef_idx,
    input  logic [COEF_W-1:0]    coef_data,
    input  logic [SHIFT_W-1:0]   cfg_shift
);

    localparam int ACC_W = PIX_W + COEF_W + 5;
    // Shift field must hold the fixed >>4 of the blur kernel as well as cfg_shift.
    localparam int SH_W  = (SHIFT_W > 3) ? SHIFT_W : 3;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    logic                     en;
    logic                     accept;

    logic signed [COEF_W-1:0] coef_q   [9];
    logic signed [ACC_W-1:0]  pix_ext  [9];
    logic signed [ACC_W-1:0]  coef_ext [9];

    logic signed [ACC_W-1:0]  term_d   [9];
    logic signed [ACC_W-1:0]  term_q   [9];
    logic [SH_W-1:0]          sh1_d;
    logic [SH_W-1:0]          sh1_q;
    logic                     v1_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum2_q;
    logic [SH_W-1:0]          sh2_q;
    logic                     v2_q;

    logic signed [ACC_W-1:0]  shifted;
    logic [PIX_W-1:0]         res_d;
    logic                     out_valid_q;
    logic [PIX_W-1:0]         data_out_q;

    assign en        = !out_valid_q || out_ready;
    assign accept    = in_valid && en;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

    for (genvar g = 0; g < 9; g++) begin : g_ext
        assign pix_ext[g]  = $signed({{(ACC_W-PIX_W){1'b0}}, win_in[g*PIX_W +: PIX_W]});
        assign coef_ext[g] = $signed({{(ACC_W-COEF_W){coef_q[g][COEF_W-1]}}, coef_q[g]});
    end

    // A beat sampled in the same cycle as a write sees the pre-write coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                coef_q[k] <= (k == 4) ? COEF_W'(1) : '0;
            end
        end else if (coef_we && (coef_idx <= 4'd8)) begin
            coef_q[coef_idx] <= coef_data;
        end
    end

    always_comb begin
        sh1_d = '0;
        case (func)
            3'b001:  sh1_d = SH_W'(4);
            3'b100:  sh1_d = SH_W'(cfg_shift);
            default: sh1_d = '0;
        endcase
        for (int k = 0; k < 9; k++) begin
            term_d[k] = '0;
            case (func)
                3'b000: term_d[k] = (k == 4) ? (pix_ext[k] <<< 3) + pix_ext[k] : -pix_ext[k];
                3'b001: begin
                    if (k == 4)          term_d[k] = pix_ext[k] <<< 2;
                    else if (k % 2 == 1) term_d[k] = pix_ext[k] <<< 1;
                    else                 term_d[k] = pix_ext[k];
                end
                3'b010: begin
                    if (k == 4)          term_d[k] = (pix_ext[k] <<< 2) + pix_ext[k];
                    else if (k % 2 == 1) term_d[k] = -pix_ext[k];
                    else                 term_d[k] = '0;
                end
                3'b100:  term_d[k] = pix_ext[k] * coef_ext[k];
                default: term_d[k] = (k == 4) ? pix_ext[k] : '0;
            endcase
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + term_q[k];
        end
    end

    always_comb begin
        shifted = sum2_q >>> sh2_q;
        res_d   = shifted[PIX_W-1:0];
        if (SAT != 0) begin
            if (shifted < 0)            res_d = '0;
            else if (shifted > PIX_MAX) res_d = '1;
        end
    end

    // The whole pipe moves in lockstep on en, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sh1_q       <= '0;
            for (int k = 0; k < 9; k++) begin
                term_q[k] <= '0;
            end
            v2_q        <= 1'b0;
            sum2_q      <= '0;
            sh2_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else if (en) begin
            v1_q <= accept;
            if (accept) begin
                term_q <= term_d;
                sh1_q  <= sh1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sum2_q <= sum_d;
                sh2_q  <= sh1_q;
            end
            out_valid_q <= v2_q;
            if (v2_q) begin
                data_out_q <= res_d;
            end
        end
    end

endmodule
